// File: rtl/serial_to_para.sv
// serial_to_para: gathers NUM_WORDS words from a valid/ready word stream into
// one wide block, first word in the MSBs, and hands the block downstream over
// a second valid/ready handshake.
module serial_to_para #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W-1:0]             word_in,
    output logic                          block_valid,
    input  logic                          block_ready,
    output logic [NUM_WORDS*WORD_W-1:0]   block_out,
    output logic [CNT_W-1:0]              word_count
);

    localparam int unsigned BLOCK_W = NUM_WORDS * WORD_W;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BLOCK_W-1:0]   block_q, block_d;

    assign in_ready    = (state_q == FILL) && !clear;
    assign block_valid = (state_q == FULL);
    assign block_out   = block_q;
    assign word_count  = count_q;

    // State, word counter and block storage; everything returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            block_q <= block_d;
        end
    end

    // Next-state logic: clear wins, otherwise fill slots in FILL and wait for the consumer in FULL.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        block_d = block_q;
        if (clear) begin
            // Partial block is abandoned but its slots are left as-is; the next fill overwrites them.
            state_d = FILL;
            count_d = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_valid) begin
                        // Slot k sits at a constant offset, so select it by comparing the count.
                        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
                            if (count_q == CNT_W'(k)) begin
                                block_d[(NUM_WORDS-k)*WORD_W-1 -: WORD_W] = word_in;
                            end
                        end
                        if (count_q == CNT_W'(NUM_WORDS - 1)) begin
                            count_d = '0;
                            state_d = FULL;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (block_ready) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_to_para.sv
// Testbench for serial_to_para: reference model of the word slots, a queue of
// expected blocks popped at each consumer handshake, a small vector table and
// hand-written sequences for backpressure, streaming, gaps, clear and reset.
module tb_serial_to_para;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  word_in;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_out;
    logic [3:0]   word_count;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int           m_cnt;
    logic         m_full;
    logic [511:0] m_blk;
    logic [511:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic        br;
        logic        clr;
        int          exp_cnt;
        logic        exp_valid;
        logic        exp_ready;
    } vec_t;

    vec_t tbl[7];

    serial_to_para #(
        .WORD_W   (32),
        .NUM_WORDS(16),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .word_in    (word_in),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .block_out  (block_out),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_full = 1'b0;
        m_blk  = '0;
        exp_q.delete();
    endtask

    // Drive one cycle (called at edge+1), update the model at the edge, compare at edge+1.
    task automatic cyc(input logic v, input logic [31:0] w, input logic br, input logic clr);
        logic [511:0] e;
        in_valid    = v;
        word_in     = w;
        block_ready = br;
        clear       = clr;
        if (block_valid && br && !clr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_block", block_out, '0);
                chk("unexpected_block_valid", {511'd0, block_valid}, 512'd0);
            end else begin
                e = exp_q.pop_front();
                chk("block_data", block_out, e);
            end
        end
        @(posedge clk);
        if (clr) begin
            if (m_full && exp_q.size() > 0) void'(exp_q.pop_front());
            m_cnt  = 0;
            m_full = 1'b0;
        end else if (!m_full) begin
            if (v) begin
                m_blk[(16-m_cnt)*32-1 -: 32] = w;
                m_cnt++;
                if (m_cnt == 16) begin
                    m_cnt  = 0;
                    m_full = 1'b1;
                    exp_q.push_back(m_blk);
                end
            end
        end else if (br) begin
            m_full = 1'b0;
        end
        #1;
        chk("word_count", {508'd0, word_count}, 512'(m_cnt));
        chk("block_valid", {511'd0, block_valid}, {511'd0, m_full});
        chk("in_ready", {511'd0, in_ready}, {511'd0, (!m_full && !clr)});
        chk("block_out", block_out, m_blk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; word_in = '0; block_ready = 1'b0; clear = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill16(input logic [31:0] base, input logic rand_words);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, rand_words ? $urandom() : base + 32'(i), 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; word_in = '0; block_ready = 1'b0; clear = 1'b0;
        model_reset();
        #1;
        chk("reset_count", {508'd0, word_count}, 512'd0);
        chk("reset_valid", {511'd0, block_valid}, 512'd0);
        chk("reset_block", block_out, 512'd0);
        chk("reset_in_ready", {511'd0, in_ready}, 512'd1);
        @(posedge clk);
        #1;
        chk("reset_hold_count", {508'd0, word_count}, 512'd0);
        rst_n = 1'b1;

        // vector table: accepts, gap, clear priority, block_ready don't-care in FILL
        tbl[0] = '{1'b1, 32'h000000a1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 32'h11111111, 1'b0, 1'b0, 1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 32'h000000a2, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 32'hbadbadba, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h000000b1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 32'h22222222, 1'b1, 1'b0, 1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 32'h000000b2, 1'b1, 1'b0, 2, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].v, tbl[i].w, tbl[i].br, tbl[i].clr);
            chk($sformatf("tbl%0d_count", i), {508'd0, word_count}, 512'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_valid", i), {511'd0, block_valid}, {511'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_ready", i), {511'd0, in_ready}, {511'd0, tbl[i].exp_ready});
        end
        chk("tbl_slot1", block_out[479:448], 512'h000000b2);
        chk("tbl_slot0", block_out[511:480], 512'h000000b1);

        // fill 1..16 with consumer stalled
        do_reset();
        fill16(32'h1, 1'b0);
        chk("fill_block_const", block_out,
            512'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008_00000009_0000000a_0000000b_0000000c_0000000d_0000000e_0000000f_00000010);
        chk("fill_valid", {511'd0, block_valid}, 512'd1);
        chk("fill_in_ready", {511'd0, in_ready}, 512'd0);

        // backpressure: input ignored while FULL
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'hdeadbeef, 1'b0, 1'b0);
        chk("bp_slot15", block_out[31:0], 512'h00000010);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bp_release_valid", {511'd0, block_valid}, 512'd0);
        chk("bp_release_ready", {511'd0, in_ready}, 512'd1);

        // streaming: consumer always ready, 3 blocks at 17 cycles each
        for (int i = 0; i < 51; i++) cyc(1'b1, $urandom(), 1'b1, 1'b0);
        chk("stream_drained", 512'(exp_q.size()), 512'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // gaps: pattern word, idle, idle, word, ...
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'h5a000000 | 32'(i), 1'b0, 1'b0);
            if (i % 2 == 0 && i != 15) begin
                cyc(1'b0, 32'hffffffff, 1'b0, 1'b0);
                cyc(1'b0, 32'hffffffff, 1'b0, 1'b0);
            end
        end
        chk("gap_block", block_out,
            512'h5a000000_5a000001_5a000002_5a000003_5a000004_5a000005_5a000006_5a000007_5a000008_5a000009_5a00000a_5a00000b_5a00000c_5a00000d_5a00000e_5a00000f);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // clear after 7 words, then a full clean block
        for (int i = 0; i < 7; i++) cyc(1'b1, $urandom(), 1'b0, 1'b0);
        cyc(1'b1, 32'hcafef00d, 1'b0, 1'b1);
        chk("clear_count", {508'd0, word_count}, 512'd0);
        chk("clear_not_stored", 512'(block_out[511:480] == 32'hcafef00d), 512'd0);
        fill16(32'h0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // asynchronous reset mid-fill
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'h77000000 | 32'(i), 1'b0, 1'b0);
        in_valid = 1'b0; block_ready = 1'b0; clear = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_block", block_out, 512'd0);
        chk("async_rst_count", {508'd0, word_count}, 512'd0);
        chk("async_rst_valid", {511'd0, block_valid}, 512'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        fill16(32'h0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
